// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder family: sequencer state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR gate,
// shared by the serial adder family.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g1;
  logic g2;

  // First half adder combines the operand bits, second folds in the carry.
  assign p  = x ^ y;
  assign g1 = x & y;
  assign s  = p ^ ci;
  assign g2 = p & ci;
  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder: one full-adder cell is reused LSB first across WIDTH
// clocks, with valid/ready handshakes on the operand and result sides.
module serial_adder_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)         state_next = RUN;
      RUN:     if (cnt == LAST_BIT)  state_next = DONE;
      DONE:    if (out_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // New sum bit enters at the MSB so the result lands aligned after WIDTH shifts.
  always_comb begin
    sum_next           = sum_r >> 1;
    sum_next[WIDTH-1]  = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        sum_r <= sum_next;
        carry <= fa_co;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed self-checking bench for serial_adder_sequencer, covering a
// WIDTH=4 instance and a WIDTH=1 instance side by side.
module tb_serial_adder_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] sum;
  logic       cout;
  logic       busy;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] sum1;
  logic       cout1;
  logic       busy1;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  serial_adder_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_sequencer #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Full WIDTH=4 transaction: accept, wait for the result, optionally stall
  // the consumer for 'hold' cycles, then complete the handshake.
  task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb,
                               input logic tc, input int hold, input string tag);
    logic [4:0] expected;
    int lat;
    expected = 5'(ta) + 5'(tb) + 5'(tc);
    @(negedge clk);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tc;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'd4);
    checkOutput({tag, ".sum"}, 32'(sum), 32'(expected[3:0]));
    checkOutput({tag, ".cout"}, 32'(cout), 32'(expected[4]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, ".hold_sum"}, 32'(sum), 32'(expected[3:0]));
      checkOutput({tag, ".hold_cout"}, 32'(cout), 32'(expected[4]));
      checkOutput({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    #12;
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.sum", 32'(sum), 32'd0);
    checkOutput("reset.cout", 32'(cout), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd9, 4'd7, 1'b0, 0, "add9_7");
    applyStimulus(4'd15, 4'd15, 1'b1, 0, "add15_15_1");
    applyStimulus(4'd0, 4'd0, 1'b0, 0, "add0_0");
    applyStimulus(4'd5, 4'd6, 1'b0, 5, "backpressure");

    // Operand beat offered during RUN must be dropped.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd4;
    b = 4'd2;
    cin = 1'b1;
    @(posedge clk);
    #1;
    a = 4'd3;
    b = 4'd3;
    cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("ignore.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    lat = 2;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ignore.latency", 32'(lat), 32'd4);
    checkOutput("ignore.sum", 32'(sum), 32'd7);
    checkOutput("ignore.cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ignore.ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ignore.no_restart", 32'(busy), 32'd0);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst.busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.sum", 32'(sum), 32'd0);
    checkOutput("rst.cout", 32'(cout), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst.no_result", 32'(out_valid), 32'd0);
    applyStimulus(4'd1, 4'd2, 1'b0, 0, "after_rst");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          applyStimulus(4'(i), 4'(j), 1'(k), 0, $sformatf("sweep_%0d_%0d_%0d", i, j, k));
        end
      end
    end

    // Single-bit build: one RUN cycle before the result.
    @(negedge clk);
    checkOutput("w1.in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("w1.latency", 32'(lat), 32'd1);
    checkOutput("w1.sum", 32'(sum1), 32'd1);
    checkOutput("w1.cout", 32'(cout1), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("w1.valid_drop", 32'(out_valid1), 32'd0);
    @(negedge clk);
    in_valid1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b0;
    cin1 = 1'b0;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("w1b.valid", 32'(out_valid1), 32'd1);
    checkOutput("w1b.sum", 32'(sum1), 32'd1);
    checkOutput("w1b.cout", 32'(cout1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
